wishbone_cmd_master: RTL and testbench
======================================

# wishbone_cmd_master

Single-outstanding Wishbone bus master that sits on the master port of the address-decoding interconnect. It turns a valid/ready command stream (from the host bridge) into Wishbone classic cycles and returns a valid/ready response stream. It also watches the interconnect's aggregate interrupt line; on a rising edge it reads the interrupt status word at the interconnect's interrupt address (slave select 0xFF) and reports it.

## Interface
- TIMEOUT, 16'd1000: cycles to wait for ack before aborting a cycle; legal range 1..65535
- INT_ADDR, 32'hFF000000: address read to fetch interrupt status
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  high only in IDLE with no interrupt fetch pending
- i_cmd_we  in  1  1 = write, 0 = read
- i_cmd_adr  in  32  target address; bits 31:24 are the slave select
- i_cmd_dat  in  32  write data
- i_cmd_sel  in  4  byte lanes
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  response consumer ready
- o_rsp_dat  out  32  read data; 0 for writes and timeouts
- o_rsp_err  out  1  1 = cycle timed out
- o_int_strobe  out  1  one-cycle pulse: new interrupt status available
- o_int_status  out  32  last interrupt status word read
- o_m_we, o_m_cyc, o_m_stb  out  1 each  Wishbone controls
- o_m_sel  out  4  Wishbone byte select
- o_m_adr, o_m_dat  out  32 each  Wishbone address and write data
- i_m_dat  in  32  Wishbone read data
- i_m_ack  in  1  Wishbone ack
- i_m_int  in  1  aggregate interrupt from the interconnect

## Operation
- States: IDLE, CMD_BUS, CMD_RSP, INT_BUS.
- IDLE: if int_pending, load INT_ADDR (we=0, sel=4'hF), go to INT_BUS. Else if i_cmd_valid, register we/adr/dat/sel, go to CMD_BUS.
- Arbitration: an interrupt fetch wins over a command in the same cycle; o_cmd_ready is low whenever int_pending is set.
- int_pending: set on a rising edge of i_m_int (registered i_m_int compared with the current value). Cleared when INT_BUS exits. An edge arriving during INT_BUS re-sets it after the exit, so another fetch follows.
- CMD_BUS: cyc=stb=1. On i_m_ack: capture i_m_dat (reads only, writes capture 0), err=0, drop cyc/stb, go to CMD_RSP. On timeout: dat=0, err=1, drop cyc/stb, go to CMD_RSP.
- CMD_RSP: o_rsp_valid=1 with dat/err held stable until i_rsp_ready, then go to IDLE.
- INT_BUS: cyc=stb=1. On ack: o_int_status<=i_m_dat, pulse o_int_strobe. On timeout: status unchanged, no pulse. Either way go to IDLE.
- Timeout counter: 16 bits, cleared on entry to any bus state, increments each cycle without ack. The cycle aborts when count==TIMEOUT-1 and ack is low.
- Outside bus states, o_m_we, o_m_stb, o_m_cyc and o_m_sel are 0. o_m_adr and o_m_dat hold their last value.

## Timing
- Reset values: all outputs 0, state IDLE, int_pending 0, registered i_m_int 0.
- Reset asserted mid-cycle: cyc/stb drop immediately (asynchronous). Any in-flight response or interrupt fetch is discarded.
- Handshake: a command accepted at edge T puts cyc/stb/adr on the bus from T through the ack edge.
- Ack sampled at edge T+k: cyc/stb are low from T+k. o_rsp_valid is high from T+k. Minimum command-to-response latency is one edge after acceptance plus ack latency.
- All Wishbone outputs are registered. i_m_ack and i_m_dat are sampled only while cyc=1; a stray ack in IDLE is ignored.
- Back-to-back: after a response handshake, the next command can be accepted on the following edge (one IDLE cycle).
- Ack on exactly the timeout cycle: ack wins, err=0.

## Structure
- Shared package holds the state encoding and the default constants (INT_ADDR, TIMEOUT default).
- No sub-module, except an optional wb_timeout_counter (load/clear, terminal flag) when it is reused by other masters.

## Test plan
- Write 0x01000010 ← 0xDEADBEEF, sel=F, slave acks 2 cycles after stb → bus shows adr/dat/we=1; o_rsp_valid with dat=0, err=0.
- Read 0x00000004, slave returns 0x12345678 with ack → o_rsp_dat=0x12345678, err=0. Hold i_rsp_ready low 5 cycles → response stays stable and o_cmd_ready stays low.
- Read 0x05000000 with no ack and TIMEOUT=8 → cyc drops after exactly 8 cycles of stb; rsp dat=0, err=1.
- i_m_int rises while idle, bus returns 0x00000002 at 0xFF000000 → one o_int_strobe pulse, o_int_status=2, no rsp_valid.
- i_cmd_valid and an i_m_int rise in the same cycle → interrupt read first, then the command executes; both complete correctly.
- rst asserted during CMD_BUS → cyc/stb/rsp_valid go to 0 asynchronously. After release, a new read completes normally.

Source files
------------

// File: rtl/wishbone_cmd_master_pkg.sv
// Shared definitions for the single-outstanding Wishbone command master:
// FSM state encoding and default bus constants.
package wishbone_cmd_master_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmdBus,
        StCmdRsp,
        StIntBus
    } state_e;

    localparam logic [15:0] DefaultTimeout = 16'd1000;
    localparam logic [31:0] DefaultIntAddr = 32'hFF00_0000;
    localparam logic [3:0]  SelAll         = 4'hF;

endpackage

// File: rtl/wishbone_cmd_master.sv
// Single-outstanding Wishbone classic master: turns a valid/ready command stream into bus
// cycles, returns responses, and fetches interrupt status on a rising edge of i_m_int.
module wishbone_cmd_master
    import wishbone_cmd_master_pkg::*;
#(
    parameter logic [15:0] TIMEOUT  = DefaultTimeout,
    parameter logic [31:0] INT_ADDR = DefaultIntAddr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_adr,
    input  logic [31:0] i_cmd_dat,
    input  logic [3:0]  i_cmd_sel,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_dat,
    output logic        o_rsp_err,
    output logic        o_int_strobe,
    output logic [31:0] o_int_status,
    output logic        o_m_we,
    output logic        o_m_cyc,
    output logic        o_m_stb,
    output logic [3:0]  o_m_sel,
    output logic [31:0] o_m_adr,
    output logic [31:0] o_m_dat,
    input  logic [31:0] i_m_dat,
    input  logic        i_m_ack,
    input  logic        i_m_int
);

    state_e      state_q, state_d;
    logic        int_q;
    logic        int_pend_q, int_pend_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] mdat_q, mdat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] int_status_q, int_status_d;
    logic        int_strobe_q, int_strobe_d;

    logic        int_rise;
    logic        cnt_expired;
    logic        bus_d;

    assign int_rise    = i_m_int && !int_q;
    assign cnt_expired = (cnt_q == TIMEOUT - 16'd1);

    // A rise seen this very cycle already blocks a command, so interrupts win ties.
    assign o_cmd_ready = (state_q == StIdle) && !int_pend_q && !int_rise;

    always_comb begin
        state_d      = state_q;
        int_pend_d   = int_pend_q || int_rise;
        cnt_d        = cnt_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        mdat_d       = mdat_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_err_d    = rsp_err_q;
        int_status_d = int_status_q;
        int_strobe_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (int_pend_q || int_rise) begin
                    // Consumed on entry; a rise during the fetch re-arms it for another fetch.
                    int_pend_d = 1'b0;
                    adr_d      = INT_ADDR;
                    we_d       = 1'b0;
                    sel_d      = SelAll;
                    cnt_d      = '0;
                    state_d    = StIntBus;
                end else if (i_cmd_valid) begin
                    we_d    = i_cmd_we;
                    adr_d   = i_cmd_adr;
                    mdat_d  = i_cmd_dat;
                    sel_d   = i_cmd_sel;
                    cnt_d   = '0;
                    state_d = StCmdBus;
                end
            end
            StCmdBus: begin
                cnt_d = cnt_q + 16'd1;
                if (i_m_ack) begin
                    rsp_dat_d = we_q ? 32'd0 : i_m_dat;
                    rsp_err_d = 1'b0;
                    state_d   = StCmdRsp;
                end else if (cnt_expired) begin
                    rsp_dat_d = 32'd0;
                    rsp_err_d = 1'b1;
                    state_d   = StCmdRsp;
                end
            end
            StCmdRsp: begin
                if (i_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            StIntBus: begin
                cnt_d = cnt_q + 16'd1;
                if (i_m_ack) begin
                    int_status_d = i_m_dat;
                    int_strobe_d = 1'b1;
                    state_d      = StIdle;
                end else if (cnt_expired) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        bus_d       = (state_d == StCmdBus) || (state_d == StIntBus);
        cyc_d       = bus_d;
        rsp_valid_d = (state_d == StCmdRsp);
        if (!bus_d) begin
            we_d  = 1'b0;
            sel_d = 4'h0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            int_q        <= 1'b0;
            int_pend_q   <= 1'b0;
            cnt_q        <= '0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'h0;
            adr_q        <= '0;
            mdat_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_err_q    <= 1'b0;
            int_status_q <= '0;
            int_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_q        <= i_m_int;
            int_pend_q   <= int_pend_d;
            cnt_q        <= cnt_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            mdat_q       <= mdat_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_err_q    <= rsp_err_d;
            int_status_q <= int_status_d;
            int_strobe_q <= int_strobe_d;
        end
    end

    assign o_m_cyc      = cyc_q;
    assign o_m_stb      = cyc_q;
    assign o_m_we       = we_q;
    assign o_m_sel      = sel_q;
    assign o_m_adr      = adr_q;
    assign o_m_dat      = mdat_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_dat    = rsp_dat_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_int_status = int_status_q;
    assign o_int_strobe = int_strobe_q;

endmodule

// File: tb/tb_wishbone_cmd_master.sv
// Self-checking bench for wishbone_cmd_master: behavioural slave with word memory,
// reference memory model, directed scenarios and randomized command/interrupt traffic.
module tb_wishbone_cmd_master;

    localparam logic [15:0] TO   = 16'd8;
    localparam logic [31:0] IADR = 32'hFF00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_valid, o_cmd_ready, i_cmd_we;
    logic [31:0] i_cmd_adr, i_cmd_dat;
    logic [3:0]  i_cmd_sel;
    logic        o_rsp_valid, i_rsp_ready, o_rsp_err;
    logic [31:0] o_rsp_dat;
    logic        o_int_strobe;
    logic [31:0] o_int_status;
    logic        o_m_we, o_m_cyc, o_m_stb;
    logic [3:0]  o_m_sel;
    logic [31:0] o_m_adr, o_m_dat, i_m_dat;
    logic        i_m_ack, i_m_int;

    int checks = 0;
    int errors = 0;

    logic [31:0] slv_mem [16];
    logic [31:0] ref_mem [16];
    int          slv_delay = 0;
    bit          slv_noack = 0;
    bit          slv_stray = 0;
    logic [31:0] int_word  = '0;
    int          stb_cnt = 0;
    int          last_stb_len = 0;
    int          strobe_cnt = 0;
    int          rsp_cycles = 0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic        log_we[$];
    logic [3:0]  log_sel[$];

    always #5 clk = ~clk;

    wishbone_cmd_master #(.TIMEOUT(TO), .INT_ADDR(IADR)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
        .i_cmd_adr(i_cmd_adr), .i_cmd_dat(i_cmd_dat), .i_cmd_sel(i_cmd_sel),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dat(o_rsp_dat),
        .o_rsp_err(o_rsp_err), .o_int_strobe(o_int_strobe), .o_int_status(o_int_status),
        .o_m_we(o_m_we), .o_m_cyc(o_m_cyc), .o_m_stb(o_m_stb), .o_m_sel(o_m_sel),
        .o_m_adr(o_m_adr), .o_m_dat(o_m_dat), .i_m_dat(i_m_dat), .i_m_ack(i_m_ack),
        .i_m_int(i_m_int)
    );

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Slave: acks after slv_delay stb cycles without ack; slave select 0xFF returns int_word.
    initial begin
        i_m_ack = 1'b0;
        i_m_dat = '0;
        forever begin
            @(posedge clk);
            #1;
            if (o_m_cyc && o_m_stb) begin
                stb_cnt++;
                if (stb_cnt == 1) begin
                    log_adr.push_back(o_m_adr);
                    log_dat.push_back(o_m_dat);
                    log_we.push_back(o_m_we);
                    log_sel.push_back(o_m_sel);
                end
                if (!slv_noack && stb_cnt > slv_delay) begin
                    i_m_ack = 1'b1;
                    if (o_m_we) begin
                        if (o_m_adr[31:24] != 8'hFF)
                            slv_mem[o_m_adr[5:2]] = lane_merge(slv_mem[o_m_adr[5:2]], o_m_dat,
                                                               o_m_sel);
                        i_m_dat = 32'hCAFE_F00D;
                    end else begin
                        i_m_dat = (o_m_adr[31:24] == 8'hFF) ? int_word : slv_mem[o_m_adr[5:2]];
                    end
                end else begin
                    i_m_ack = 1'b0;
                end
            end else begin
                if (stb_cnt > 0) last_stb_len = stb_cnt;
                stb_cnt = 0;
                i_m_ack = slv_stray;
                i_m_dat = slv_stray ? 32'hBAD0_BAD0 : 32'h0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_int_strobe) strobe_cnt++;
            if (o_rsp_valid) rsp_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        int n;
        i_cmd_we = we; i_cmd_adr = adr; i_cmd_dat = dat; i_cmd_sel = sel;
        i_cmd_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (o_cmd_ready) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL cmd_accept_timeout got ready=0 want ready=1 within 100 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] dat, output logic err);
        int n;
        i_rsp_ready = 1'b1;
        n = 0;
        dat = 'x; err = 1'bx;
        forever begin
            if (o_rsp_valid) begin
                dat = o_rsp_dat; err = o_rsp_err;
                break;
            end
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL rsp_wait_timeout got valid=0 want valid=1 within 100 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        i_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_cmd_valid = 0; i_cmd_we = 0; i_cmd_adr = 0; i_cmd_dat = 0; i_cmd_sel = 0;
        i_rsp_ready = 0; i_m_int = 0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = 32'h1111_1111 * i;
            ref_mem[i] = 32'h1111_1111 * i;
        end
        tick(3);
        checks++;
        if ({o_m_cyc, o_m_stb, o_m_we, o_m_sel, o_m_adr, o_m_dat, o_rsp_valid, o_rsp_dat,
             o_rsp_err, o_int_strobe, o_int_status} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got cyc=%b rsp_valid=%b adr=%h status=%h want all 0",
                     o_m_cyc, o_rsp_valid, o_m_adr, o_int_status);
        end
        rst = 1'b1;
        tick(2);
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 1", o_cmd_ready);
        end
    endtask

    task automatic test_write();
        int lat;
        logic [31:0] d;
        logic e;
        slv_delay = 2; slv_noack = 0;
        log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
        send_cmd(1'b1, 32'h0100_0010, 32'hDEAD_BEEF, 4'hF);
        lat = 0;
        @(negedge clk);
        while (!o_rsp_valid && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != slv_delay + 1 || o_m_cyc !== 1'b0) begin
            errors++;
            $display("FAIL write_latency got %0d cyc=%b want %0d cyc=0", lat, o_m_cyc,
                     slv_delay + 1);
        end
        get_rsp(d, e);
        ref_mem[4] = lane_merge(ref_mem[4], 32'hDEAD_BEEF, 4'hF);
        checks++;
        if ({e, d} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL write_rsp got err=%b dat=%h want err=0 dat=0", e, d);
        end
        checks++;
        if (log_adr.size() != 1 || {log_adr[0], log_dat[0], log_we[0], log_sel[0]} !==
            {32'h0100_0010, 32'hDEAD_BEEF, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL write_bus got n=%0d adr=%h dat=%h we=%b want adr=01000010 dat=deadbeef we=1",
                     log_adr.size(), log_adr[0], log_dat[0], log_we[0]);
        end
    endtask

    task automatic test_read_backpressure();
        int n;
        logic [31:0] d;
        logic e;
        slv_mem[1] = 32'h1234_5678; ref_mem[1] = 32'h1234_5678;
        slv_delay = 1;
        log_we.delete(); log_adr.delete(); log_dat.delete(); log_sel.delete();
        send_cmd(1'b0, 32'h0000_0004, 32'h5555_AAAA, 4'hF);
        n = 0;
        while (!o_rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({o_rsp_valid, o_rsp_err, o_rsp_dat, o_cmd_ready} !==
                {1'b1, 1'b0, 32'h1234_5678, 1'b0}) begin
                errors++;
                $display("FAIL read_hold[%0d] got v=%b e=%b d=%h rdy=%b want v=1 e=0 d=12345678 rdy=0",
                         c, o_rsp_valid, o_rsp_err, o_rsp_dat, o_cmd_ready);
            end
        end
        get_rsp(d, e);
        checks++;
        if ({e, d, log_we[0], log_sel[0]} !== {1'b0, 32'h1234_5678, 1'b0, 4'hF}) begin
            errors++;
            $display("FAIL read_rsp got err=%b dat=%h we=%b want err=0 dat=12345678 we=0",
                     e, d, log_we[0]);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d, exp_d, adr;
        logic e, exp_e;
        for (int k = 0; k < 3; k++) begin
            slv_noack = (k == 0);
            slv_delay = (k == 1) ? int'(TO) - 1 : int'(TO);
            adr = 32'h0500_0000 + 32'(k * 4);
            send_cmd(1'b0, adr, 32'h0, 4'hF);
            get_rsp(d, e);
            exp_e = (k != 1);
            exp_d = exp_e ? 32'h0 : ref_mem[k];
            checks++;
            if ({e, d} !== {exp_e, exp_d}) begin
                errors++;
                $display("FAIL timeout_rsp[%0d] got err=%b dat=%h want err=%b dat=%h",
                         k, e, d, exp_e, exp_d);
            end
            checks++;
            if (last_stb_len != int'(TO)) begin
                errors++;
                $display("FAIL timeout_stb_len[%0d] got %0d want %0d", k, last_stb_len, TO);
            end
        end
        slv_noack = 0;
    endtask

    task automatic test_interrupt();
        int s0, r0, n;
        int_word = 32'h0000_0002; slv_delay = 1;
        s0 = strobe_cnt; r0 = rsp_cycles;
        log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
        i_m_int = 1'b1;
        n = 0;
        while (strobe_cnt == s0 && n < 50) begin
            tick(1);
            n++;
        end
        tick(4);
        checks++;
        if (strobe_cnt - s0 != 1 || o_int_status !== 32'h2 || rsp_cycles != r0) begin
            errors++;
            $display("FAIL int_fetch got pulses=%0d status=%h rsp=%0d want pulses=1 status=2 rsp=0",
                     strobe_cnt - s0, o_int_status, rsp_cycles - r0);
        end
        checks++;
        if (log_adr.size() != 1 || {log_adr[0], log_we[0], log_sel[0]} !== {IADR, 1'b0, 4'hF})
        begin
            errors++;
            $display("FAIL int_bus got n=%0d adr=%h we=%b sel=%h want adr=%h we=0 sel=f",
                     log_adr.size(), log_adr[0], log_we[0], log_sel[0], IADR);
        end
        i_m_int = 1'b0;
        tick(2);
    endtask

    task automatic test_arbitration();
        int s0;
        logic [31:0] d;
        logic e;
        int_word = 32'h0000_0030; slv_delay = 0;
        s0 = strobe_cnt;
        log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
        i_m_int = 1'b1;
        send_cmd(1'b0, 32'h0200_0008, 32'h0, 4'h3);
        get_rsp(d, e);
        tick(3);
        checks++;
        if ({e, d} !== {1'b0, ref_mem[2]}) begin
            errors++;
            $display("FAIL arb_rsp got err=%b dat=%h want err=0 dat=%h", e, d, ref_mem[2]);
        end
        checks++;
        if (log_adr.size() != 2 || log_adr[0] !== IADR || log_adr[1] !== 32'h0200_0008) begin
            errors++;
            $display("FAIL arb_order got n=%0d first=%h second=%h want first=%h second=02000008",
                     log_adr.size(), log_adr[0], log_adr[1], IADR);
        end
        checks++;
        if (strobe_cnt - s0 != 1 || o_int_status !== 32'h30) begin
            errors++;
            $display("FAIL arb_int got pulses=%0d status=%h want pulses=1 status=30",
                     strobe_cnt - s0, o_int_status);
        end
        i_m_int = 1'b0;
        tick(2);
    endtask

    task automatic test_stray_ack();
        int s0, r0;
        s0 = strobe_cnt; r0 = rsp_cycles;
        slv_stray = 1;
        tick(6);
        checks++;
        if ({o_cmd_ready, o_m_cyc} !== 2'b10 || strobe_cnt != s0 || rsp_cycles != r0) begin
            errors++;
            $display("FAIL stray_ack got rdy=%b cyc=%b pulses=%0d rsp=%0d want rdy=1 cyc=0 0 0",
                     o_cmd_ready, o_m_cyc, strobe_cnt - s0, rsp_cycles - r0);
        end
        slv_stray = 0;
        tick(1);
    endtask

    task automatic test_random();
        logic        we, e, exp_e, do_int, int_early;
        logic [31:0] adr, dat, d, exp_d;
        logic [3:0]  sel;
        int          idx, s0;
        for (int it = 0; it < 40; it++) begin
            we = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            adr = {8'($urandom_range(0, 5)), 18'($urandom), 4'(idx), 2'b00};
            dat = $urandom;
            sel = 4'($urandom_range(1, 15));
            slv_delay = $urandom_range(0, 9);
            do_int = ($urandom_range(0, 3) == 0);
            int_early = 1'($urandom_range(0, 1));
            int_word = $urandom;
            s0 = strobe_cnt;
            if (do_int && int_early) i_m_int = 1'b1;
            send_cmd(we, adr, dat, sel);
            if (do_int && !int_early) i_m_int = 1'b1;
            tick($urandom_range(0, 3));
            get_rsp(d, e);
            exp_e = (slv_delay >= int'(TO));
            exp_d = (we || exp_e) ? 32'h0 : ref_mem[idx];
            if (we && !exp_e) ref_mem[idx] = lane_merge(ref_mem[idx], dat, sel);
            checks++;
            if ({e, d} !== {exp_e, exp_d}) begin
                errors++;
                $display("FAIL rand_rsp[%0d] got err=%b dat=%h want err=%b dat=%h",
                         it, e, d, exp_e, exp_d);
            end
            if (do_int) begin
                tick(int'(TO) + 6);
                checks++;
                if (strobe_cnt - s0 != (exp_e ? 0 : 1) ||
                    (!exp_e && o_int_status !== int_word)) begin
                    errors++;
                    $display("FAIL rand_int[%0d] got pulses=%0d status=%h want pulses=%0d status=%h",
                             it, strobe_cnt - s0, o_int_status, exp_e ? 0 : 1, int_word);
                end
                i_m_int = 1'b0;
                tick(1);
            end
        end
        slv_delay = 0;
        for (int i = 0; i < 16; i++) begin
            send_cmd(1'b0, {8'h01, 22'h0, 4'(i), 2'b00}, 32'h0, 4'hF);
            get_rsp(d, e);
            checks++;
            if ({e, d} !== {1'b0, ref_mem[i]}) begin
                errors++;
                $display("FAIL mem_sweep[%0d] got err=%b dat=%h want err=0 dat=%h",
                         i, e, d, ref_mem[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic e;
        slv_noack = 1;
        send_cmd(1'b0, 32'h0300_0000, 32'h0, 4'hF);
        tick(3);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({o_m_cyc, o_m_stb, o_rsp_valid, o_int_status} !== '0) begin
            errors++;
            $display("FAIL async_reset got cyc=%b stb=%b rsp_valid=%b status=%h want all 0",
                     o_m_cyc, o_m_stb, o_rsp_valid, o_int_status);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        slv_noack = 0;
        slv_delay = 2;
        tick(2);
        send_cmd(1'b0, 32'h0300_0014, 32'h0, 4'hF);
        get_rsp(d, e);
        checks++;
        if ({e, d} !== {1'b0, ref_mem[5]}) begin
            errors++;
            $display("FAIL post_reset_read got err=%b dat=%h want err=0 dat=%h", e, d, ref_mem[5]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_backpressure();
        test_timeout();
        test_interrupt();
        test_arbitration();
        test_stray_ack();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
